// File: rtl/bcd_a_binario.sv
// Sequential BCD-to-binary converter: three latched BCD digits are folded into a
// binary value one digit per clock (acc = acc*10 + digit), flagging bad digits and overflow.
module bcd_a_binario #(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       C,
  input  logic [3:0]       D,
  input  logic [3:0]       U,
  output logic [OUT_W-1:0] O,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned ACC_W   = 10;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned MAX_VAL = (2 ** OUT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   hun_q, hun_d;
  logic [DIG_W-1:0]   ten_q, ten_d;
  logic [DIG_W-1:0]   uni_q, uni_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bad_q, bad_d;
  logic [OUT_W-1:0]   o_q, o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DIG_W-1:0]   digit;
  logic               overflow;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hun_q   <= '0;
      ten_q   <= '0;
      uni_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      uni_q   <= uni_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONV;
      ST_CONV: if (idx_q == IDX_W'(2)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit selected by the current iteration, most significant first
  always_comb begin
    case (idx_q)
      2'd0:    digit = hun_q;
      2'd1:    digit = ten_q;
      default: digit = uni_q;
    endcase
  end

  assign overflow = (32'(acc_q) > MAX_VAL);

  // Datapath and registered-output updates
  always_comb begin
    hun_d  = hun_q;
    ten_d  = ten_q;
    uni_d  = uni_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    bad_d  = bad_q;
    o_d    = o_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hun_d  = C;
          ten_d  = D;
          uni_d  = U;
          acc_d  = '0;
          idx_d  = '0;
          bad_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      ST_CONV: begin
        // acc*10 as (acc<<3)+(acc<<1); bad digits still flow through the loop
        acc_d = ACC_W'((acc_q << 3) + (acc_q << 1) + ACC_W'(digit));
        if (digit > DIG_W'(9)) bad_d = 1'b1;
        idx_d = IDX_W'(idx_q + IDX_W'(1));
        if (idx_q == IDX_W'(2)) busy_d = 1'b0;
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (bad_q || overflow) begin
          o_d   = '0;
          err_d = 1'b1;
        end else begin
          o_d   = OUT_W'(acc_q);
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign O    = o_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Self-checking bench for bcd_a_binario: directed scenarios plus random conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd_a_binario;

  localparam int unsigned OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       C, D, U;
  logic [OUT_W-1:0] O;
  logic             busy, done, err;

  int checks = 0;
  int errors = 0;

  bcd_a_binario #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .C(C), .D(D), .U(U),
    .O(O), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the three digits, rejected if any digit is not BCD or it exceeds OUT_W bits
  function automatic void ref_conv(input int c, input int d, input int u,
                                   output logic [OUT_W-1:0] o, output logic e);
    int v;
    if (c > 9 || d > 9 || u > 9) begin
      o = '0;
      e = 1'b1;
    end else begin
      v = 100 * c + 10 * d + u;
      if (v > (2 ** OUT_W) - 1) begin
        o = '0;
        e = 1'b1;
      end else begin
        o = OUT_W'(v);
        e = 1'b0;
      end
    end
  endfunction

  // Pulses start with the given digits and returns edges until done (start edge = 1), -1 on timeout
  task automatic run_conv(input int c, input int d, input int u, output int n);
    C = 4'(c); D = 4'(d); U = 4'(u);
    start = 1'b1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; C = 4'd0; D = 4'd0; U = 4'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({O, busy, done, err} !== '0) begin
        errors++;
        $display("FAIL reset_hold: O=%0d busy=%b done=%b err=%b, required all 0", O, busy, done, err);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({O, busy, done, err} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: O=%0d busy=%b done=%b err=%b, required all 0", i, O, busy, done, err);
      end
    end
  endtask

  task automatic test_nominal();
    C = 4'd1; D = 4'd2; U = 4'd3;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      checks++;
      if (busy !== (i < 3) || done !== (i == 4)) begin
        errors++;
        $display("FAIL nominal_timing edge %0d: busy=%b done=%b, required busy=%b done=%b",
                 i, busy, done, i < 3, i == 4);
      end
    end
    checks++;
    if (O !== 8'd123 || err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_result: O=%0d err=%b, required O=123 err=0", O, err);
    end
    tick();
    checks++;
    if (O !== 8'd123 || done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_hold: O=%0d done=%b, required O=123 done=0", O, done);
    end
  endtask

  task automatic test_back_to_back();
    int vals[6] = '{0, 99, 100, 255, 256, 999};
    int n;
    logic [OUT_W-1:0] eo;
    logic ee;
    foreach (vals[k]) begin
      ref_conv(vals[k] / 100, (vals[k] / 10) % 10, vals[k] % 10, eo, ee);
      run_conv(vals[k] / 100, (vals[k] / 10) % 10, vals[k] % 10, n);
      checks++;
      if (n !== 5) begin
        errors++;
        $display("FAIL b2b_gap value %0d: %0d edges to done, required 5", vals[k], n);
      end
      checks++;
      if (O !== eo || err !== ee) begin
        errors++;
        $display("FAIL b2b_result value %0d: O=%0d err=%b, required O=%0d err=%b", vals[k], O, err, eo, ee);
      end
    end
  endtask

  task automatic test_invalid_digit();
    int n;
    run_conv(0, 10, 5, n);
    checks++;
    if (n !== 5 || O !== 8'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_digit: n=%0d O=%0d err=%b, required n=5 O=0 err=1", n, O, err);
    end
    run_conv(0, 4, 2, n);
    checks++;
    if (n !== 5 || O !== 8'd42 || err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_recover: n=%0d O=%0d err=%b, required n=5 O=42 err=0", n, O, err);
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int late_busy = 0;
    C = 4'd2; D = 4'd0; U = 4'd7;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 2) begin
        C = 4'(9); D = 4'(9); U = 4'($urandom_range(0, 9));
      end
      if (i == 5) start = 1'b0;
      if (i >= 6 && busy) late_busy++;
      if (done) begin
        dones++;
        checks++;
        if (O !== 8'd207 || err !== 1'b0) begin
          errors++;
          $display("FAIL ignored_result: O=%0d err=%b, required O=207 err=0", O, err);
        end
      end
    end
    checks++;
    if (dones !== 1 || late_busy !== 0) begin
      errors++;
      $display("FAIL ignored_single: done pulses=%0d late busy cycles=%0d, required 1 and 0", dones, late_busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int stray = 0;
    C = 4'd2; D = 4'd0; U = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({O, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: O=%0d busy=%b done=%b err=%b, required all 0", O, busy, done, err);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with busy/done, required 0", stray);
    end
    run_conv(0, 5, 0, n);
    checks++;
    if (n !== 5 || O !== 8'd50 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart: n=%0d O=%0d err=%b, required n=5 O=50 err=0", n, O, err);
    end
  endtask

  task automatic test_random();
    int c, d, u, n;
    logic [OUT_W-1:0] eo;
    logic ee;
    for (int k = 0; k < 40; k++) begin
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 3));
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      u = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      ref_conv(c, d, u, eo, ee);
      run_conv(c, d, u, n);
      checks++;
      if (n !== 5 || O !== eo || err !== ee) begin
        errors++;
        $display("FAIL random %0d digits %0d,%0d,%0d: n=%0d O=%0d err=%b, required n=5 O=%0d err=%b",
                 k, c, d, u, n, O, err, eo, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_invalid_digit();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
